// File: rtl/mmio_periph_pkg.sv
// Shared register map, bus width and control-register layout for the mmio_periph peripheral.
package mmio_periph_pkg;

    localparam int REG_BUS = 32;

    // Byte offsets within the 256-byte window; addr[1:0] is masked before decode
    localparam logic [7:0] MMIO_LED  = 8'h00;
    localparam logic [7:0] MMIO_SW   = 8'h04;
    localparam logic [7:0] MMIO_CNT  = 8'h08;
    localparam logic [7:0] MMIO_CMP  = 8'h0C;
    localparam logic [7:0] MMIO_CTRL = 8'h10;
    localparam logic [7:0] MMIO_STAT = 8'h14;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTOCLR = 1;
    localparam int CTRL_IRQEN   = 2;

    typedef struct packed {
        logic irqen;
        logic autoclr;
        logic en;
    } ctrl_t;

    function automatic ctrl_t unpack_ctrl(input logic [REG_BUS-1:0] word);
        ctrl_t c;
        c.en      = word[CTRL_EN];
        c.autoclr = word[CTRL_AUTOCLR];
        c.irqen   = word[CTRL_IRQEN];
        return c;
    endfunction

endpackage

// File: rtl/mmio_periph_sw_debounce.sv
// Switch input conditioning: 2-flop synchronizer, plus a stability filter when MMIO_DEBOUNCE_EN is defined.
module sw_debounce #(
    parameter int WIDTH           = 12,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch_on,
    output logic [WIDTH-1:0] sw_q
);

    logic [WIDTH-1:0] sync_1;
    logic [WIDTH-1:0] sw_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1  <= '0;
            sw_sync <= '0;
        end else begin
            sync_1  <= switch_on;
            sw_sync <= sync_1;
        end
    end

`ifdef MMIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] sw_last;
    logic [CW-1:0]    db_cnt;

    // A fresh value counts as its first stable cycle, so sw_q follows
    // DEBOUNCE_CYCLES edges after sw_sync settles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_last <= '0;
            sw_q    <= '0;
            db_cnt  <= '0;
        end else begin
            sw_last <= sw_sync;
            if (sw_sync == sw_q) begin
                db_cnt <= '0;
            end else if (sw_sync != sw_last) begin
                db_cnt <= CW'(1);
            end else if (db_cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
                sw_q   <= sw_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end
`else
    assign sw_q = sw_sync;
`endif

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped LED/switch/compare-timer responder on the data-memory bus.
// Optional switch debounce filter is enabled by defining MMIO_DEBOUNCE_EN.
module mmio_periph
    import mmio_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               we,
    input  logic [REG_BUS-1:0] addr,
    input  logic [REG_BUS-1:0] data_i,
    output logic [REG_BUS-1:0] data_o,
    output logic               hit_o,
    input  logic [11:0]        switch_on,
    output logic [REG_BUS-1:0] led_out,
    output logic               irq_o
);

    logic [7:0]         offset;
    logic               wr;
    logic               rd;
    logic [REG_BUS-1:0] cnt;
    logic [REG_BUS-1:0] cmp;
    ctrl_t              ctrl;
    logic               match;
    logic               match_now;
    logic [11:0]        sw_q;

    assign hit_o  = ce && (addr[31:8] == BASE_ADDR[31:8]);
    assign offset = addr[7:0] & 8'hFC;
    assign wr     = ce && we && hit_o;
    assign rd     = ce && !we && hit_o;

    sw_debounce #(
        .WIDTH          (12),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk      (clk),
        .rst      (rst),
        .switch_on(switch_on),
        .sw_q     (sw_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out <= '0;
            cmp     <= '0;
            ctrl    <= '0;
        end else if (wr) begin
            if (offset == MMIO_LED)  led_out <= data_i;
            if (offset == MMIO_CMP)  cmp     <= data_i;
            if (offset == MMIO_CTRL) ctrl    <= unpack_ctrl(data_i);
        end
    end

    assign match_now = ctrl.en && (cnt == cmp);

    // A bus write to CNT beats the timer's own increment/clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (wr && offset == MMIO_CNT) begin
            cnt <= data_i;
        end else if (ctrl.en) begin
            if (match_now && ctrl.autoclr) cnt <= '0;
            else                           cnt <= cnt + 1'b1;
        end
    end

    // Hardware match set wins over a simultaneous write-1-to-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match <= 1'b0;
        end else if (match_now) begin
            match <= 1'b1;
        end else if (wr && offset == MMIO_STAT && data_i[0]) begin
            match <= 1'b0;
        end
    end

    assign irq_o = match && ctrl.irqen;

    always_comb begin
        data_o = '0;
        if (rd) begin
            case (offset)
                MMIO_LED:  data_o = led_out;
                MMIO_SW:   data_o = {20'b0, sw_q};
                MMIO_CNT:  data_o = cnt;
                MMIO_CMP:  data_o = cmp;
                MMIO_CTRL: data_o = {29'b0, ctrl};
                MMIO_STAT: data_o = {31'b0, match};
                default:   data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_periph.sv
// Scoreboard bench for mmio_periph: reads push expected data, a negedge monitor pops and compares.
module tb_mmio_periph;

    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef MMIO_DEBOUNCE_EN
    localparam int SW_LAT = 18;
`else
    localparam int SW_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        hit_o;
    logic [11:0] switch_on;
    logic [31:0] led_out;
    logic        irq_o;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mmio_periph dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .we       (we),
        .addr     (addr),
        .data_i   (data_i),
        .data_o   (data_o),
        .hit_o    (hit_o),
        .switch_on(switch_on),
        .led_out  (led_out),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Each bus task starts at a negedge and occupies exactly one clock cycle
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = a; data_i = d;
        @(negedge clk);
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        ce = 1'b1; we = 1'b0; addr = a;
        sb.push_back('{name, exp});
        @(negedge clk);
        ce = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        #2;
        if (ce && !we && hit_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_read: got %h want none", data_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output(e.name, data_o, e.value);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; data_i = '0; switch_on = '0;
        idle(2);
        #1;
        check_output("rst_led", led_out, 32'h0);
        check_output("rst_irq", {31'b0, irq_o}, 32'h0);
        check_output("rst_data_o", data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        bus_read(BASE + 32'h00, 32'h0, "rd_led_reset");
        bus_read(BASE + 32'h10, 32'h0, "rd_ctrl_reset");

        bus_write(BASE + 32'h00, 32'hA5A5_0F0F);
        #1 check_output("led_after_write", led_out, 32'hA5A5_0F0F);
        bus_read(BASE + 32'h00, 32'hA5A5_0F0F, "rd_led");
        bus_read(BASE + 32'h03, 32'hA5A5_0F0F, "rd_led_lowbits");

        ce = 1'b1; we = 1'b1; addr = BASE + 32'h100; data_i = 32'h0;
        #1 check_output("hit_outside", {31'b0, hit_o}, 32'h0);
        @(negedge clk);
        ce = 1'b0; we = 1'b0;
        #1 check_output("led_outside_write", led_out, 32'hA5A5_0F0F);
        ce = 1'b1; addr = BASE + 32'h100;
        #1 check_output("data_outside_read", data_o, 32'h0);
        @(negedge clk);
        ce = 1'b0;

        bus_write(BASE + 32'h18, 32'hFFFF_FFFF);
        bus_read(BASE + 32'h18, 32'h0, "rd_unmapped");
        bus_write(BASE + 32'h10, 32'h0000_00F2);
        bus_read(BASE + 32'h10, 32'h2, "rd_ctrl_masked");

        // Auto-clear timer: CNT 0,1,2,3,0 with IRQ after the match
        bus_write(BASE + 32'h0C, 32'd3);
        bus_write(BASE + 32'h10, 32'h7);
        bus_read(BASE + 32'h08, 32'd0, "cnt_seq0");
        bus_read(BASE + 32'h08, 32'd1, "cnt_seq1");
        bus_read(BASE + 32'h08, 32'd2, "cnt_seq2");
        bus_read(BASE + 32'h08, 32'd3, "cnt_seq3");
        bus_read(BASE + 32'h08, 32'd0, "cnt_seq_clr");
        #1 check_output("irq_on_match", {31'b0, irq_o}, 32'h1);
        bus_write(BASE + 32'h14, 32'h1);
        #1 check_output("irq_after_w1c", {31'b0, irq_o}, 32'h0);
        bus_write(BASE + 32'h10, 32'h0);
        bus_read(BASE + 32'h14, 32'h0, "stat_cleared");

        // W1C landing on the match edge must lose to the hardware set
        bus_write(BASE + 32'h08, 32'd0);
        bus_write(BASE + 32'h0C, 32'd2);
        bus_write(BASE + 32'h10, 32'h5);
        idle(2);
        bus_write(BASE + 32'h14, 32'h1);
        #1 check_output("irq_w1c_collide", {31'b0, irq_o}, 32'h1);
        bus_read(BASE + 32'h14, 32'h1, "stat_w1c_collide");
        bus_read(BASE + 32'h08, 32'd4, "cnt_after_match");

        bus_write(BASE + 32'h08, 32'hFFFF_FFFF);
        bus_read(BASE + 32'h08, 32'hFFFF_FFFF, "cnt_write_override");
        bus_read(BASE + 32'h08, 32'h0, "cnt_wrap");
        bus_write(BASE + 32'h10, 32'h0);
        bus_write(BASE + 32'h14, 32'h1);
        bus_read(BASE + 32'h14, 32'h0, "stat_clear2");
        bus_read(BASE + 32'h08, 32'd2, "cnt_hold_disabled");

        switch_on = 12'hABC;
        idle(SW_LAT - 1);
        bus_read(BASE + 32'h04, 32'h0, "sw_before_latency");
        bus_read(BASE + 32'h04, 32'h0000_0ABC, "sw_after_latency");
`ifdef MMIO_DEBOUNCE_EN
        switch_on = 12'h555;
        idle(5);
        switch_on = 12'hABC;
        idle(25);
        bus_read(BASE + 32'h04, 32'h0000_0ABC, "sw_glitch");
`endif

        // Reset mid-run with MATCH set and a write pending
        bus_write(BASE + 32'h08, 32'd0);
        bus_write(BASE + 32'h0C, 32'd1);
        bus_write(BASE + 32'h10, 32'h7);
        idle(4);
        #1 check_output("irq_before_rst", {31'b0, irq_o}, 32'h1);
        ce = 1'b1; we = 1'b1; addr = BASE; data_i = 32'h1234_5678;
        rst = 1'b1;
        #1;
        check_output("rst_mid_led", led_out, 32'h0);
        check_output("rst_mid_irq", {31'b0, irq_o}, 32'h0);
        @(negedge clk);
        ce = 1'b0; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus_read(BASE + 32'h00, 32'h0, "led_post_rst");
        bus_read(BASE + 32'h0C, 32'h0, "cmp_post_rst");
        bus_read(BASE + 32'h10, 32'h0, "ctrl_post_rst");
        bus_read(BASE + 32'h14, 32'h0, "stat_post_rst");
        idle(3);
        bus_read(BASE + 32'h08, 32'h0, "cnt_idle_post_rst");
        bus_write(BASE + 32'h10, 32'h1);
        bus_read(BASE + 32'h08, 32'd0, "cnt_resume0");
        bus_read(BASE + 32'h08, 32'd1, "cnt_resume1");

        idle(2);
        check_output("sb_drain", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
